// File: rtl/hs32_wb_pkg.sv
// hs32 writeback arbiter shared types.
// Request bundle, grant source and write-enable decode.
package hs32_wb_pkg;

    typedef struct packed {
        logic [3:0]  addr;
        logic        bank;
        logic        hi_only;
        logic [31:0] data;
    } wb_req_t;

    typedef struct packed {
        logic we1;
        logic we2;
        logic wel;
        logic bad;
    } wp_en_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EX   = 2'd1,
        GNT_LSU  = 2'd2
    } grant_t;

    // Widest starvation counter the block is ever built with.
    localparam int STARVE_CNT_W_MAX = 8;

    // Counter width able to hold 0..limit.
    function automatic int starve_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

    // Bank 1 only has 8 entries, so addr[3]=1 there has no target.
    function automatic wp_en_t to_wp(input wb_req_t req);
        wp_en_t en;
        en.bad = req.bank & req.addr[3];
        en.we1 = ~en.bad & ~req.bank;
        en.we2 = ~en.bad & req.bank;
        en.wel = ~en.bad & ~req.hi_only;
        return en;
    endfunction

endpackage

// File: rtl/hs32_wb_fifo.sv
// hs32 writeback LSU buffer.
// Pointer FIFO of writeback requests, power-of-2 depth.
module hs32_wb_fifo
    import hs32_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  wb_req_t                    i_data,
    input  logic                       i_pop,
    output wb_req_t                    o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage write; contents need no reset, pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hs32_wb_arbiter.sv
// hs32 register-file writeback arbiter.
// EX has priority; buffered LSU results win when starved.
module hs32_wb_arbiter
    import hs32_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ex_valid_i,
    output logic                        ex_ready_o,
    input  logic [3:0]                  ex_addr_i,
    input  logic                        ex_bank_i,
    input  logic                        ex_hi_only_i,
    input  logic [31:0]                 ex_data_i,
    input  logic                        lsu_valid_i,
    output logic                        lsu_ready_o,
    input  logic [3:0]                  lsu_addr_i,
    input  logic                        lsu_bank_i,
    input  logic                        lsu_hi_only_i,
    input  logic [31:0]                 lsu_data_i,
    output logic [3:0]                  wp1_addr_o,
    output logic [31:0]                 wp1_data_o,
    output logic                        wp1_we1_o,
    output logic                        wp1_we2_o,
    output logic                        wp1_wel_o,
    output logic [$clog2(FIFO_DEPTH):0] lsu_count_o,
    output logic                        bad_bank_o,
    output logic                        idle_o
);

    localparam int SW = starve_cnt_w(STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    wb_req_t        w_ex_req;
    wb_req_t        w_lsu_req;
    wb_req_t        w_head;
    wb_req_t        w_sel;
    wp_en_t         w_en;
    grant_t         w_grant;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_starve;

    logic [SW-1:0]  r_starve_cnt;
    logic [3:0]     r_addr;
    logic [31:0]    r_data;
    logic           r_we1;
    logic           r_we2;
    logic           r_wel;
    logic           r_bad;

    assign w_ex_req  = '{addr: ex_addr_i, bank: ex_bank_i,
                         hi_only: ex_hi_only_i, data: ex_data_i};
    assign w_lsu_req = '{addr: lsu_addr_i, bank: lsu_bank_i,
                         hi_only: lsu_hi_only_i, data: lsu_data_i};

    assign w_starve    = (r_starve_cnt == LIMIT);
    assign ex_ready_o  = ~w_starve;
    assign lsu_ready_o = ~w_full;
    assign w_push      = lsu_valid_i & lsu_ready_o;
    assign w_pop       = (w_grant == GNT_LSU);

    hs32_wb_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_lsu_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (lsu_count_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pick the single writer for this cycle.
    always_comb begin
        w_grant = GNT_NONE;
        if (ex_valid_i && !w_starve) begin
            w_grant = GNT_EX;
        end else if (!w_empty) begin
            w_grant = GNT_LSU;
        end
    end

    // Route the granted request and decode its enables.
    always_comb begin
        w_sel = w_ex_req;
        unique case (w_grant)
            GNT_LSU: w_sel = w_head;
            default: w_sel = w_ex_req;
        endcase
        w_en = to_wp(w_sel);
    end

    // Count EX wins while LSU data waits; any LSU drain restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (w_grant == GNT_EX && !w_starve) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    // Register the granted write; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
            r_we1  <= 1'b0;
            r_we2  <= 1'b0;
            r_wel  <= 1'b0;
            r_bad  <= 1'b0;
        end else begin
            r_we1 <= 1'b0;
            r_we2 <= 1'b0;
            r_wel <= 1'b0;
            r_bad <= 1'b0;
            if (w_grant != GNT_NONE) begin
                r_addr <= w_sel.addr;
                r_data <= w_sel.data;
                r_we1  <= w_en.we1;
                r_we2  <= w_en.we2;
                r_wel  <= w_en.wel;
                r_bad  <= w_en.bad;
            end
        end
    end

    assign wp1_addr_o = r_addr;
    assign wp1_data_o = r_data;
    assign wp1_we1_o  = r_we1;
    assign wp1_we2_o  = r_we2;
    assign wp1_wel_o  = r_wel;
    assign bad_bank_o = r_bad;
    assign idle_o     = w_empty & ~r_we1 & ~r_we2;

endmodule

// File: tb/tb_hs32_wb_arbiter.sv
// hs32 writeback arbiter bench.
// Directed table, corner sequences, random vs queue model.
module tb_hs32_wb_arbiter;
    import hs32_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic [3:0]      ex_addr_i;
    logic            ex_bank_i;
    logic            ex_hi_only_i;
    logic [31:0]     ex_data_i;
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [3:0]      lsu_addr_i;
    logic            lsu_bank_i;
    logic            lsu_hi_only_i;
    logic [31:0]     lsu_data_i;
    logic [3:0]      wp1_addr_o;
    logic [31:0]     wp1_data_o;
    logic            wp1_we1_o;
    logic            wp1_we2_o;
    logic            wp1_wel_o;
    logic [CNTW-1:0] lsu_count_o;
    logic            bad_bank_o;
    logic            idle_o;

    always #5 clk = ~clk;

    hs32_wb_arbiter #(
        .FIFO_DEPTH    (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_addr_i     (ex_addr_i),
        .ex_bank_i     (ex_bank_i),
        .ex_hi_only_i  (ex_hi_only_i),
        .ex_data_i     (ex_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_bank_i    (lsu_bank_i),
        .lsu_hi_only_i (lsu_hi_only_i),
        .lsu_data_i    (lsu_data_i),
        .wp1_addr_o    (wp1_addr_o),
        .wp1_data_o    (wp1_data_o),
        .wp1_we1_o     (wp1_we1_o),
        .wp1_we2_o     (wp1_we2_o),
        .wp1_wel_o     (wp1_wel_o),
        .lsu_count_o   (lsu_count_o),
        .bad_bank_o    (bad_bank_o),
        .idle_o        (idle_o)
    );

    typedef struct packed {
        logic            we1;
        logic            we2;
        logic            wel;
        logic [3:0]      addr;
        logic [31:0]     data;
        logic            bad;
        logic [CNTW-1:0] cnt;
        logic            exr;
        logic            lsr;
        logic            idle;
    } obs_t;

    typedef struct {
        logic        exv;
        logic [3:0]  exa;
        logic        exb;
        logic        exh;
        logic [31:0] exd;
        logic        lv;
        logic [3:0]  la;
        logic        lb;
        logic        lh;
        logic [31:0] ld;
        obs_t        exp;
    } vec_t;

    int n_run;
    int n_fail;

    // Reference model: LSU buffer as a queue, outputs as plain state.
    wb_req_t     m_q[$];
    int          m_cnt;
    logic        m_we1, m_we2, m_wel, m_bad;
    logic [3:0]  m_addr;
    logic [31:0] m_data;

    function automatic obs_t mk(input logic we1, input logic we2,
                                input logic wel, input logic [3:0] a,
                                input logic [31:0] d, input logic bad,
                                input int cnt, input logic exr,
                                input logic lsr, input logic idle);
        obs_t o;
        o.we1  = we1;
        o.we2  = we2;
        o.wel  = wel;
        o.addr = a;
        o.data = d;
        o.bad  = bad;
        o.cnt  = CNTW'(cnt);
        o.exr  = exr;
        o.lsr  = lsr;
        o.idle = idle;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.we1  = wp1_we1_o;
        o.we2  = wp1_we2_o;
        o.wel  = wp1_wel_o;
        o.addr = wp1_addr_o;
        o.data = wp1_data_o;
        o.bad  = bad_bank_o;
        o.cnt  = lsu_count_o;
        o.exr  = ex_ready_o;
        o.lsr  = lsu_ready_o;
        o.idle = idle_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.we1  = m_we1;
        o.we2  = m_we2;
        o.wel  = m_wel;
        o.addr = m_addr;
        o.data = m_data;
        o.bad  = m_bad;
        o.cnt  = CNTW'(m_q.size());
        o.exr  = (m_cnt != LIMIT);
        o.lsr  = (m_q.size() < DEPTH);
        o.idle = (m_q.size() == 0) && !m_we1 && !m_we2;
        return o;
    endfunction

    task automatic model_step();
        wb_req_t r;
        int      pre;
        bit      starve;
        bit      g;
        bit      popped;
        bit      ex_g;
        if (reset) begin
            m_q.delete();
            m_cnt  = 0;
            m_we1  = 0;
            m_we2  = 0;
            m_wel  = 0;
            m_bad  = 0;
            m_addr = 0;
            m_data = 0;
            return;
        end
        pre    = m_q.size();
        starve = (m_cnt == LIMIT);
        g      = 0;
        popped = 0;
        ex_g   = 0;
        r      = '0;
        if (ex_valid_i && !starve) begin
            r = '{addr: ex_addr_i, bank: ex_bank_i,
                  hi_only: ex_hi_only_i, data: ex_data_i};
            g    = 1;
            ex_g = 1;
        end else if (pre > 0) begin
            r      = m_q.pop_front();
            g      = 1;
            popped = 1;
        end
        if (lsu_valid_i && pre < DEPTH) begin
            m_q.push_back('{addr: lsu_addr_i, bank: lsu_bank_i,
                            hi_only: lsu_hi_only_i, data: lsu_data_i});
        end
        if (popped || pre == 0) m_cnt = 0;
        else if (ex_g) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
        m_we1 = 0;
        m_we2 = 0;
        m_wel = 0;
        m_bad = 0;
        if (g) begin
            m_addr = r.addr;
            m_data = r.data;
            m_bad  = r.bank && r.addr[3];
            m_we1  = !m_bad && !r.bank;
            m_we2  = !m_bad && r.bank;
            m_wel  = !m_bad && !r.hi_only;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic expect_obs(input string name, input obs_t want);
        obs_t got;
        got = dut_obs();
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_model(input string name);
        expect_obs(name, model_obs());
    endtask

    task automatic expect_eq(input string name, input logic [63:0] got,
                             input logic [63:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drive_idle();
        ex_valid_i    = 0;
        ex_addr_i     = 0;
        ex_bank_i     = 0;
        ex_hi_only_i  = 0;
        ex_data_i     = 0;
        lsu_valid_i   = 0;
        lsu_addr_i    = 0;
        lsu_bank_i    = 0;
        lsu_hi_only_i = 0;
        lsu_data_i    = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    function automatic vec_t mkv(input logic exv, input logic [3:0] exa,
                                 input logic exb, input logic exh,
                                 input logic [31:0] exd, input logic lv,
                                 input logic [3:0] la, input logic lb,
                                 input logic lh, input logic [31:0] ld,
                                 input obs_t e);
        vec_t v;
        v.exv = exv;
        v.exa = exa;
        v.exb = exb;
        v.exh = exh;
        v.exd = exd;
        v.lv  = lv;
        v.la  = la;
        v.lb  = lb;
        v.lh  = lh;
        v.ld  = ld;
        v.exp = e;
        return v;
    endfunction

    vec_t        vecs[9];
    logic [31:0] wr[$];
    logic [31:0] lw[$];
    int          nrdy0;
    int          nxt;
    bit          acc;
    bit          saw_full;
    bit          stale;

    initial begin
        n_run  = 0;
        n_fail = 0;
        vecs[0] = mkv(1, 4'd5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                      mk(1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 1, 1, 0));
        vecs[1] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      mk(0, 0, 0, 5, 32'hDEADBEEF, 0, 0, 1, 1, 1));
        vecs[2] = mkv(1, 4'd3, 1, 1, 32'h12340000, 0, 0, 0, 0, 0,
                      mk(0, 1, 0, 3, 32'h12340000, 0, 0, 1, 1, 0));
        vecs[3] = mkv(1, 4'd9, 1, 0, 32'hCAFE0001, 0, 0, 0, 0, 0,
                      mk(0, 0, 0, 9, 32'hCAFE0001, 1, 0, 1, 1, 1));
        vecs[4] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      mk(0, 0, 0, 9, 32'hCAFE0001, 0, 0, 1, 1, 1));
        vecs[5] = mkv(1, 4'd8, 0, 0, 32'h00000011, 0, 0, 0, 0, 0,
                      mk(1, 0, 1, 8, 32'h00000011, 0, 0, 1, 1, 0));
        vecs[6] = mkv(0, 0, 0, 0, 0, 1, 4'd2, 0, 1, 32'h00000022,
                      mk(0, 0, 0, 8, 32'h00000011, 0, 1, 1, 1, 0));
        vecs[7] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      mk(1, 0, 0, 2, 32'h00000022, 0, 0, 1, 1, 0));
        vecs[8] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      mk(0, 0, 0, 2, 32'h00000022, 0, 0, 1, 1, 1));

        drive_idle();
        reset = 1;
        tick();
        tick();
        expect_obs("reset", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        reset = 0;

        for (int i = 0; i < 9; i++) begin
            ex_valid_i    = vecs[i].exv;
            ex_addr_i     = vecs[i].exa;
            ex_bank_i     = vecs[i].exb;
            ex_hi_only_i  = vecs[i].exh;
            ex_data_i     = vecs[i].exd;
            lsu_valid_i   = vecs[i].lv;
            lsu_addr_i    = vecs[i].la;
            lsu_bank_i    = vecs[i].lb;
            lsu_hi_only_i = vecs[i].lh;
            lsu_data_i    = vecs[i].ld;
            tick();
            expect_obs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Starvation: EX held high, one LSU entry waiting.
        do_reset();
        wr.delete();
        nrdy0 = 0;
        for (int k = 0; k < 10; k++) begin
            ex_valid_i  = 1;
            ex_addr_i   = 4'd1;
            ex_data_i   = 32'h100 + k;
            lsu_valid_i = (k == 0);
            lsu_addr_i  = 4'd7;
            lsu_data_i  = 32'hA5A5A5A5;
            tick();
            check_model("starve_seq");
            if (wp1_we1_o || wp1_we2_o) wr.push_back(wp1_data_o);
            if (!ex_ready_o) nrdy0++;
        end
        expect_eq("starve_nwr", wr.size(), 10);
        if (wr.size() > 5)
            expect_eq("starve_lsu_slot", wr[5], 32'hA5A5A5A5);
        expect_eq("starve_rdy_low", nrdy0, 1);
        expect_eq("starve_rdy_end", ex_ready_o, 1);

        // LSU overflow under EX pressure; order must hold.
        do_reset();
        lw.delete();
        nxt      = 1;
        saw_full = 0;
        for (int k = 0; k < 24; k++) begin
            ex_valid_i  = 1;
            ex_addr_i   = 4'd1;
            ex_data_i   = 32'h200 + k;
            lsu_valid_i = (nxt <= 3);
            lsu_addr_i  = 4'hE;
            lsu_data_i  = nxt;
            acc = lsu_valid_i && lsu_ready_o;
            tick();
            check_model("ovf_seq");
            if (acc) nxt++;
            if (!lsu_ready_o) saw_full = 1;
            if (wp1_we1_o && wp1_addr_o == 4'hE)
                lw.push_back(wp1_data_o);
        end
        expect_eq("ovf_full_seen", saw_full, 1);
        expect_eq("ovf_nwr", lw.size(), 3);
        if (lw.size() == 3) begin
            expect_eq("ovf_ord0", lw[0], 1);
            expect_eq("ovf_ord1", lw[1], 2);
            expect_eq("ovf_ord2", lw[2], 3);
        end

        // Fill the FIFO, then reset mid-operation.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            ex_valid_i  = 1;
            ex_addr_i   = 4'd2;
            ex_data_i   = 32'h300 + k;
            lsu_valid_i = 1;
            lsu_addr_i  = 4'd4;
            lsu_data_i  = 32'hBAD00001 + k;
            tick();
        end
        check_model("fill_full");
        drive_idle();
        reset = 1;
        tick();
        expect_obs("rst_mid", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        reset = 0;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_model("post_rst");
            if (wp1_we1_o || wp1_we2_o) stale = 1;
        end
        expect_eq("no_stale", stale, 0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            reset         = ($urandom_range(0, 149) == 0);
            ex_valid_i    = $urandom_range(0, 1);
            ex_addr_i     = 4'($urandom);
            ex_bank_i     = $urandom_range(0, 1);
            ex_hi_only_i  = $urandom_range(0, 1);
            ex_data_i     = $urandom;
            lsu_valid_i   = $urandom_range(0, 1);
            lsu_addr_i    = 4'($urandom);
            lsu_bank_i    = $urandom_range(0, 1);
            lsu_hi_only_i = $urandom_range(0, 1);
            lsu_data_i    = $urandom;
            tick();
            check_model("rand");
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
